instr_fetch_decode: RTL and testbench

- Fetch/decode stage sitting between the program counter and the execute stage.
- Drives the address input of the combinational instruction ROM and registers the returned 28-bit word.
- Resolves JMP and delay-NOP locally; everything else is split into fields and issued to execute with a valid flag.
- Execute can freeze this stage through a stall input.

---
 rtl/instr_fetch_decode.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_decode.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_decode
// Brief   : Fetch/decode stage. Drives the ROM address from the PC, resolves
//           JMP and delay-NOP locally and issues all other instructions to
//           execute as registered fields with a valid pulse.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_decode #(
  parameter int         ADDR_W  = 16,
  parameter int         INSTR_W = 28,
  parameter logic [3:0] OP_NOP  = 4'd0,
  parameter logic [3:0] OP_JMP  = 4'd1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStall,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic               oValid,
  output logic [3:0]         oOpcode,
  output logic [7:0]         oDest,
  output logic [7:0]         oSrc0,
  output logic [7:0]         oSrc1,
  output logic [15:0]        oImm,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oDelay
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DELAY = 1'b1
  } state_t;

  state_t              state_q,  state_d;
  logic [ADDR_W-1:0]   pc_q,     pc_d;
  logic [23:0]         cnt_q,    cnt_d;
  logic                valid_q,  valid_d;
  logic                delay_q,  delay_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [7:0]          dest_q,   dest_d;
  logic [7:0]          src0_q,   src0_d;
  logic [7:0]          src1_q,   src1_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;

  // Instruction slices from the ROM word for the current PC.
  logic [3:0]  w_opcode;
  logic [23:0] w_nop_count;
  assign w_opcode    = iInstruction[27:24];
  assign w_nop_count = iInstruction[23:0];

  // Next-state logic: stall holds everything, otherwise run the RUN/DELAY FSM.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    delay_d  = delay_q;
    opcode_d = opcode_q;
    dest_d   = dest_q;
    src0_d   = src0_q;
    src1_d   = src1_q;
    pc_out_d = pc_out_q;

    if (!iStall) begin
      case (state_q)
        ST_RUN: begin
          valid_d = 1'b0;
          if (w_opcode == OP_JMP) begin
            // Target goes straight onto the ROM address next cycle.
            pc_d = iInstruction[ADDR_W-1:0];
          end else if (w_opcode == OP_NOP) begin
            if (w_nop_count == 24'd0) begin
              pc_d = pc_q + 1'b1;
            end else begin
              // PC holds on the NOP; it advances when the delay expires.
              cnt_d   = w_nop_count;
              state_d = ST_DELAY;
              delay_d = 1'b1;
            end
          end else begin
            // Everything else, including unknown opcodes, goes to execute.
            valid_d  = 1'b1;
            opcode_d = w_opcode;
            dest_d   = iInstruction[23:16];
            src0_d   = iInstruction[15:8];
            src1_d   = iInstruction[7:0];
            pc_out_d = pc_q;
            pc_d     = pc_q + 1'b1;
          end
        end
        ST_DELAY: begin
          valid_d = 1'b0;
          cnt_d   = cnt_q - 24'd1;
          if (cnt_q == 24'd1) begin
            state_d = ST_RUN;
            delay_d = 1'b0;
            pc_d    = pc_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
          delay_d = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_RUN;
      pc_q     <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      delay_q  <= 1'b0;
      opcode_q <= '0;
      dest_q   <= '0;
      src0_q   <= '0;
      src1_q   <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      delay_q  <= delay_d;
      opcode_q <= opcode_d;
      dest_q   <= dest_d;
      src0_q   <= src0_d;
      src1_q   <= src1_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign oAddress = pc_q;
  assign oValid   = valid_q;
  assign oOpcode  = opcode_q;
  assign oDest    = dest_q;
  assign oSrc0    = src0_q;
  assign oSrc1    = src1_q;
  assign oImm     = {src0_q, src1_q};
  assign oPC      = pc_out_q;
  assign oDelay   = delay_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch_decode
// Brief   : Directed self-checking bench for instr_fetch_decode with a
//           behavioural combinational ROM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch_decode;

  localparam logic [3:0] OP_STO = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_LED = 4'h4;

  logic        Clock;
  logic        Reset;
  logic        iStall;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        oValid;
  logic [3:0]  oOpcode;
  logic [7:0]  oDest;
  logic [7:0]  oSrc0;
  logic [7:0]  oSrc1;
  logic [15:0] oImm;
  logic [15:0] oPC;
  logic        oDelay;

  logic [27:0] rom [0:65535];
  int n_checks;
  int n_pass;

  assign iInstruction = rom[oAddress];

  instr_fetch_decode dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStall       (iStall),
    .oAddress     (oAddress),
    .iInstruction (iInstruction),
    .oValid       (oValid),
    .oOpcode      (oOpcode),
    .oDest        (oDest),
    .oSrc0        (oSrc0),
    .oSrc1        (oSrc1),
    .oImm         (oImm),
    .oPC          (oPC),
    .oDelay       (oDelay)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 32; a++) rom[a] = 28'h0;
    rom[16'hFFFF] = 28'h0;
  endtask

  // Hold reset across 3 rising edges and release on a falling edge.
  task automatic do_reset();
    Reset  = 1'b0;
    iStall = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    int issue_cyc;
    n_checks = 0;
    n_pass   = 0;
    Reset    = 1'b0;
    iStall   = 1'b0;
    for (int a = 0; a < 65536; a++) rom[a] = 28'h0;

    // ---------------- reset + straight-line issue + stall on SUB ----------
    rom[0] = {OP_STO, 8'd0, 16'd8};
    rom[1] = {OP_STO, 8'd1, 16'd12};
    rom[2] = {OP_SUB, 8'd0, 8'd0, 8'd1};
    do_reset();
    check_eq("rst_addr",   32'(oAddress), 32'h0);
    check_eq("rst_valid",  32'(oValid),   32'h0);
    check_eq("rst_delay",  32'(oDelay),   32'h0);
    check_eq("rst_pc",     32'(oPC),      32'h0);
    check_eq("rst_opcode", 32'(oOpcode),  32'h0);
    tick();
    check_eq("sl0_valid", 32'(oValid),  32'h1);
    check_eq("sl0_pc",    32'(oPC),     32'h0);
    check_eq("sl0_imm",   32'(oImm),    32'd8);
    check_eq("sl0_op",    32'(oOpcode), 32'(OP_STO));
    tick();
    check_eq("sl1_valid", 32'(oValid), 32'h1);
    check_eq("sl1_pc",    32'(oPC),    32'h1);
    check_eq("sl1_dest",  32'(oDest),  32'h1);
    check_eq("sl1_imm",   32'(oImm),   32'd12);
    tick();
    check_eq("sl2_valid", 32'(oValid),  32'h1);
    check_eq("sl2_pc",    32'(oPC),     32'h2);
    check_eq("sl2_op",    32'(oOpcode), 32'(OP_SUB));
    check_eq("sl2_dest",  32'(oDest),   32'h0);
    check_eq("sl2_src0",  32'(oSrc0),   32'h0);
    check_eq("sl2_src1",  32'(oSrc1),   32'h1);
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stl_valid", 32'(oValid),   32'h1);
      check_eq("stl_pc",    32'(oPC),      32'h2);
      check_eq("stl_addr",  32'(oAddress), 32'h3);
      check_eq("stl_op",    32'(oOpcode),  32'(OP_SUB));
    end
    iStall = 1'b0;
    tick();
    check_eq("post_stl_valid", 32'(oValid),   32'h0);
    check_eq("post_stl_addr",  32'(oAddress), 32'h4);
    check_eq("fields_hold",    32'(oOpcode),  32'(OP_SUB));

    // ---------------- NOP 4 then LED --------------------------------------
    clear_rom();
    rom[0] = {OP_NOP_C(), 24'd4};
    rom[1] = {OP_LED, 8'hAA, 16'h1234};
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_eq("nop4_delay", 32'(oDelay),   32'h1);
      check_eq("nop4_valid", 32'(oValid),   32'h0);
      check_eq("nop4_addr",  32'(oAddress), 32'h0);
    end
    tick();
    check_eq("nop4_c5_delay", 32'(oDelay),   32'h0);
    check_eq("nop4_c5_valid", 32'(oValid),   32'h0);
    check_eq("nop4_c5_addr",  32'(oAddress), 32'h1);
    tick();
    check_eq("nop4_led_valid", 32'(oValid),  32'h1);
    check_eq("nop4_led_pc",    32'(oPC),     32'h1);
    check_eq("nop4_led_op",    32'(oOpcode), 32'(OP_LED));
    check_eq("nop4_led_imm",   32'(oImm),    32'h1234);

    // ---------------- NOP 0 then LED --------------------------------------
    rom[0] = 28'h0;
    do_reset();
    tick();
    check_eq("nop0_c1_valid", 32'(oValid),   32'h0);
    check_eq("nop0_c1_delay", 32'(oDelay),   32'h0);
    check_eq("nop0_c1_addr",  32'(oAddress), 32'h1);
    tick();
    check_eq("nop0_led_valid", 32'(oValid), 32'h1);
    check_eq("nop0_led_pc",    32'(oPC),    32'h1);

    // ---------------- jump loop -------------------------------------------
    clear_rom();
    rom[0] = {OP_STO, 8'd3, 16'd7};
    rom[5] = {OP_LED, 8'd0, 16'd0};
    rom[6] = {4'd1, 8'd0, 16'd0};
    do_reset();
    tick();
    check_eq("jl_sto_valid", 32'(oValid), 32'h1);
    check_eq("jl_sto_pc",    32'(oPC),    32'h0);
    repeat (4) tick();
    tick();
    check_eq("jl_led_valid", 32'(oValid), 32'h1);
    check_eq("jl_led_pc",    32'(oPC),    32'h5);
    tick();
    check_eq("jl_jmp_valid", 32'(oValid),   32'h0);
    check_eq("jl_jmp_addr",  32'(oAddress), 32'h0);
    tick();
    check_eq("jl_tgt_valid", 32'(oValid), 32'h1);
    check_eq("jl_tgt_pc",    32'(oPC),    32'h0);
    repeat (5) tick();
    check_eq("jl_rep_valid", 32'(oValid), 32'h1);
    check_eq("jl_rep_pc",    32'(oPC),    32'h5);

    // ---------------- stall during NOP 10 ---------------------------------
    clear_rom();
    rom[0] = {OP_NOP_C(), 24'd10};
    rom[1] = {OP_LED, 8'd1, 16'd2};
    do_reset();
    issue_cyc = 0;
    for (int c = 1; c <= 40 && issue_cyc == 0; c++) begin
      tick();
      if (c == 2) iStall = 1'b1;
      if (c == 5) iStall = 1'b0;
      if (oValid === 1'b1) issue_cyc = c;
    end
    check_eq("nop10_stall_cycle", 32'(issue_cyc), 32'd15);
    check_eq("nop10_stall_pc",    32'(oPC),       32'h1);

    // ---------------- wrap via JMP FFFF -----------------------------------
    clear_rom();
    rom[0]        = {4'd1, 8'd0, 16'hFFFF};
    rom[16'hFFFF] = {OP_LED, 8'd9, 16'h00FF};
    do_reset();
    tick();
    check_eq("wrap_jmp_addr",  32'(oAddress), 32'hFFFF);
    check_eq("wrap_jmp_valid", 32'(oValid),   32'h0);
    tick();
    check_eq("wrap_issue_pc", 32'(oPC),      32'hFFFF);
    check_eq("wrap_addr",     32'(oAddress), 32'h0);

    // ---------------- async reset mid-DELAY -------------------------------
    clear_rom();
    rom[0] = {OP_NOP_C(), 24'd100};
    do_reset();
    repeat (3) tick();
    check_eq("ar_pre_delay", 32'(oDelay), 32'h1);
    #2;
    Reset = 1'b0;
    #1;
    check_eq("ar_delay", 32'(oDelay),   32'h0);
    check_eq("ar_addr",  32'(oAddress), 32'h0);
    rom[0] = {OP_LED, 8'd4, 16'd5};
    @(negedge Clock);
    Reset = 1'b1;
    tick();
    check_eq("ar_restart_valid", 32'(oValid), 32'h1);
    check_eq("ar_restart_pc",    32'(oPC),    32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic logic [3:0] OP_NOP_C();
    return 4'd0;
  endfunction

endmodule
`default_nettype wire
